// File: rtl/mem_if_pkg.sv
// Shared definitions for the single-port valid/ready memory interface and its BIST initiator.
package mem_if_pkg;

  localparam int unsigned MEM_WIDTH = 32;
  localparam int unsigned MEM_ADDR  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_FINISH
  } bist_state_t;

  // Test pattern: seed plus zero-extended address; callers truncate to their data width.
  function automatic logic [63:0] bist_pattern(input logic [63:0] seed, input logic [63:0] addr);
    return seed + addr;
  endfunction

endpackage

// File: rtl/mem_bist_initiator.sv
// Write/read-back BIST initiator: fills an address range with a seeded pattern,
// reads it back one transaction at a time and reports errors, first failing address and timeout.
module mem_bist_initiator
  import mem_if_pkg::*;
#(
  parameter int unsigned WIDTH   = MEM_WIDTH,
  parameter int unsigned ADDR    = MEM_ADDR,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ADDR-1:0]  base_addr,
  input  logic [ADDR:0]    length,
  input  logic [WIDTH-1:0] seed,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [ADDR:0]    err_count,
  output logic [ADDR-1:0]  first_err_addr,
  output logic             m_valid,
  output logic             m_wrbar,
  output logic [ADDR-1:0]  m_addr,
  output logic [WIDTH-1:0] m_wdata,
  input  logic             m_ready,
  input  logic [WIDTH-1:0] m_rdata
);

  localparam int unsigned LW  = ADDR + 1;
  localparam int unsigned TCW = $clog2(TIMEOUT + 1);

  bist_state_t r_state, w_next;

  logic [ADDR-1:0]  r_base;
  logic [LW-1:0]    r_len;
  logic [LW-1:0]    r_idx;
  logic [WIDTH-1:0] r_seed;
  logic [TCW-1:0]   r_tcnt;

  logic             w_wait;
  logic             w_last;
  logic             w_expire;
  logic             w_mismatch;
  logic [LW-1:0]    w_idx_inc;
  logic [ADDR-1:0]  w_addr_nxt;
  logic [TCW-1:0]   w_tcnt_inc;
  logic [WIDTH-1:0] w_expect;

  always_comb begin
    w_wait     = (r_state == ST_WR_WAIT) || (r_state == ST_RD_WAIT);
    w_last     = (r_idx == r_len - LW'(1));
    w_tcnt_inc = r_tcnt + TCW'(1);
    w_expire   = w_wait && !m_ready && (w_tcnt_inc >= TCW'(TIMEOUT));
    w_idx_inc  = r_idx + LW'(1);
    w_addr_nxt = r_base + w_idx_inc[ADDR-1:0];
    // m_addr holds the address of the outstanding read throughout RD_WAIT
    w_expect   = WIDTH'(bist_pattern(64'(r_seed), 64'(m_addr)));
    w_mismatch = (m_rdata != w_expect);
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (start) w_next = (length == '0) ? ST_FINISH : ST_WR_REQ;
      ST_WR_REQ:  w_next = ST_WR_WAIT;
      ST_WR_WAIT: begin
        if (w_expire)     w_next = ST_FINISH;
        else if (m_ready) w_next = w_last ? ST_RD_REQ : ST_WR_REQ;
      end
      ST_RD_REQ:  w_next = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (w_expire)     w_next = ST_FINISH;
        else if (m_ready) w_next = w_last ? ST_FINISH : ST_RD_REQ;
      end
      ST_FINISH:  w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Request outputs are loaded from the next state so they are valid in the REQ cycle itself;
  // done trails FINISH by one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      m_valid        <= 1'b0;
      m_wrbar        <= 1'b0;
      m_addr         <= '0;
      m_wdata        <= '0;
      r_base         <= '0;
      r_len          <= '0;
      r_seed         <= '0;
      r_idx          <= '0;
      r_tcnt         <= '0;
    end else begin
      busy    <= (w_next != ST_IDLE);
      done    <= (r_state == ST_FINISH);
      m_valid <= (w_next == ST_WR_REQ) || (w_next == ST_RD_REQ);
      m_wrbar <= (w_next == ST_WR_REQ) || (w_next == ST_WR_WAIT);

      if (w_wait && !m_ready)
        r_tcnt <= w_tcnt_inc;
      else if ((r_state == ST_WR_REQ) || (r_state == ST_RD_REQ))
        r_tcnt <= '0;

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_base         <= base_addr;
            r_len          <= length;
            r_seed         <= seed;
            r_idx          <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
            timeout        <= 1'b0;
            pass           <= 1'b0;
            m_addr         <= base_addr;
            m_wdata        <= WIDTH'(bist_pattern(64'(seed), 64'(base_addr)));
          end
        end
        ST_WR_WAIT: begin
          if (w_expire) begin
            timeout <= 1'b1;
          end else if (m_ready) begin
            if (w_last) begin
              r_idx  <= '0;
              m_addr <= r_base;
            end else begin
              r_idx   <= w_idx_inc;
              m_addr  <= w_addr_nxt;
              m_wdata <= WIDTH'(bist_pattern(64'(r_seed), 64'(w_addr_nxt)));
            end
          end
        end
        ST_RD_WAIT: begin
          if (w_expire) begin
            timeout <= 1'b1;
          end else if (m_ready) begin
            if (w_mismatch) begin
              if (err_count == '0) first_err_addr <= m_addr;
              if (err_count != '1) err_count <= err_count + LW'(1);
            end
            r_idx  <= w_idx_inc;
            m_addr <= w_addr_nxt;
          end
        end
        ST_FINISH: pass <= (err_count == '0) && !timeout;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bist_initiator.sv
// Self-checking bench for mem_bist_initiator: behavioural memory with fault injection and a
// run-level reference model of transactions, results and done timing.
module tb_mem_bist_initiator;

  typedef struct {
    logic        wr;
    logic [7:0]  a;
    logic [31:0] d;
  } txrec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  base_addr;
  logic [8:0]  length;
  logic [31:0] seed;
  logic        busy, done, pass, timeout;
  logic [8:0]  err_count;
  logic [7:0]  first_err_addr;
  logic        m_valid, m_wrbar;
  logic [7:0]  m_addr;
  logic [31:0] m_wdata;
  logic        m_ready;
  logic [31:0] m_rdata;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  logic [31:0] mem   [256];
  bit          fault [256];
  bit          ready_en = 1'b1;
  txrec_t      txq[$];

  always #5 clk = ~clk;

  mem_bist_initiator #(.WIDTH(32), .ADDR(8), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length), .seed(seed),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout), .err_count(err_count),
    .first_err_addr(first_err_addr), .m_valid(m_valid), .m_wrbar(m_wrbar), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_ready(m_ready), .m_rdata(m_rdata)
  );

  // Memory: acknowledges in the cycle after m_valid, reads flip bit 0 at faulted addresses.
  initial begin
    bit          pend;
    logic        p_wr;
    logic [7:0]  p_a;
    logic [31:0] p_d;
    pend = 1'b0; p_wr = 1'b0; p_a = '0; p_d = '0;
    m_ready = 1'b0;
    m_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      m_ready = 1'b0;
      if (pend && ready_en) begin
        m_ready = 1'b1;
        if (p_wr) mem[p_a] = p_d;
        else      m_rdata = mem[p_a] ^ 32'(fault[p_a]);
      end
      pend = 1'b0;
      if (m_valid) begin
        pend = 1'b1; p_wr = m_wrbar; p_a = m_addr; p_d = m_wdata;
        txq.push_back('{m_wrbar, m_addr, m_wdata});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  task automatic clear_faults();
    for (int i = 0; i < 256; i++) fault[i] = 1'b0;
  endtask

  task automatic do_run(input logic [7:0] b, input logic [8:0] l, input logic [31:0] s,
                        input bit rdy, input bit poke);
    txrec_t      expq[$];
    int unsigned n_err;
    logic [7:0]  first_a;
    logic [7:0]  a;
    int          cnt;
    n_err = 0;
    first_a = '0;
    for (int i = 0; i < int'(l); i++) begin
      a = b + 8'(i);
      expq.push_back('{1'b1, a, s + {24'b0, a}});
    end
    for (int i = 0; i < int'(l); i++) begin
      a = b + 8'(i);
      if (fault[a]) begin
        if (n_err == 0) first_a = a;
        n_err++;
      end
      expq.push_back('{1'b0, a, 32'b0});
    end
    if (!rdy) begin
      expq.delete();
      expq.push_back('{1'b1, b, s + {24'b0, b}});
      n_err = 0;
      first_a = '0;
    end
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    ready_en = rdy;
    @(negedge clk);
    txq.delete();
    start = 1'b1; base_addr = b; length = l; seed = s;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    cnt = 0;
    while (done !== 1'b1 && cnt < 4 * int'(l) + 100) begin
      @(negedge clk);
      cnt++;
      if (poke && cnt == 5) begin start = 1'b1; base_addr = 8'h00; length = 9'd3; end
      if (poke && cnt == 6) start = 1'b0;
    end
    chk("done_seen", done, 1);
    if (rdy) chk("done_cycle", 64'(cnt), 64'(4 * int'(l) + 1));
    chk("busy_at_done", busy, 0);
    chk("pass", pass, (rdy && n_err == 0) ? 1 : 0);
    chk("timeout", timeout, rdy ? 0 : 1);
    chk("err_count", err_count, 64'(n_err));
    chk("first_err_addr", first_err_addr, first_a);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("tx_count", 64'(txq.size()), 64'(expq.size()));
    for (int i = 0; i < expq.size() && i < txq.size(); i++) begin
      chk("tx_kind", txq[i].wr, expq[i].wr);
      chk("tx_addr", txq[i].a, expq[i].a);
      if (expq[i].wr) chk("tx_wdata", txq[i].d, expq[i].d);
    end
    ready_en = 1'b1;
  endtask

  initial begin
    logic [7:0]  rb;
    logic [8:0]  rl;
    int unsigned nf;
    int          n_done, n_valid;
    rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; seed = '0;
    clear_faults();
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_first_err", first_err_addr, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_wrbar", m_wrbar, 0);
    rst = 1'b0;

    do_run(8'h10, 9'd4, 32'hA5A5_0000, 1'b1, 1'b0);
    fault[8'h12] = 1'b1; fault[8'h13] = 1'b1;
    do_run(8'h10, 9'd4, 32'hA5A5_0000, 1'b1, 1'b0);
    clear_faults();
    do_run(8'hFE, 9'd4, 32'h1234_5678, 1'b1, 1'b0);
    do_run(8'h20, 9'd0, 32'hDEAD_BEEF, 1'b1, 1'b0);
    fault[8'h05] = 1'b1;
    do_run(8'h37, 9'd256, $urandom, 1'b1, 1'b0);
    clear_faults();

    for (int r = 0; r < 6; r++) begin
      rb = 8'($urandom_range(0, 255));
      rl = 9'($urandom_range(1, 20));
      clear_faults();
      nf = $urandom_range(0, 3);
      for (int k = 0; k < int'(nf); k++) fault[rb + 8'($urandom_range(0, int'(rl) - 1))] = 1'b1;
      do_run(rb, rl, $urandom, 1'b1, 1'b0);
    end
    clear_faults();

    do_run(8'h80, 9'd5, 32'h0BAD_F00D, 1'b0, 1'b0);
    do_run(8'h30, 9'd6, 32'h5555_AAAA, 1'b1, 1'b1);

    // Reset during the read phase with errors already counted.
    fault[8'h40] = 1'b1; fault[8'h41] = 1'b1;
    @(negedge clk);
    start = 1'b1; base_addr = 8'h40; length = 9'd8; seed = 32'h0000_1000;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_m_wrbar", m_wrbar, 0);
    chk("midrst_err_count", err_count, 0);
    chk("midrst_first_err", first_err_addr, 0);
    chk("midrst_m_addr", m_addr, 0);
    chk("midrst_m_wdata", m_wdata, 0);
    n_done = 0; n_valid = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
      if (m_valid === 1'b1) n_valid++;
    end
    chk("midrst_no_done", 64'(n_done), 0);
    chk("midrst_no_valid", 64'(n_valid), 0);
    chk("midrst_idle_pass", pass, 0);
    clear_faults();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_bist_initiator.md
# mem_bist_initiator

Initiator for the single-port synchronous memory valid/ready interface. On a start pulse it writes a deterministic pattern over an address range, reads the range back, compares each word and reports pass/fail with an error count, first failing address and timeout flag. It sits between a test/bring-up controller and any memory instance using this protocol. It issues exactly one transaction at a time.

## Interface
- WIDTH, 32, data width; must match the memory.
- ADDR, 8, address width; the range wraps modulo 2^ADDR.
- TIMEOUT, 16, maximum cycles spent waiting for m_ready per transaction.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset; synchronous and active-high.
- start  in  1  single-cycle request; sampled only in IDLE.
- base_addr  in  ADDR  first address of the range.
- length  in  ADDR+1  number of words, 0..2^ADDR.
- seed  in  WIDTH  pattern seed.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a run finishes.
- pass  out  1  1 when err_count==0 and no timeout; held until the next start.
- timeout  out  1  run aborted waiting for m_ready; held until the next start.
- err_count  out  ADDR+1  number of mismatching words; saturates at 2^(ADDR+1)-1.
- first_err_addr  out  ADDR  address of the first mismatch; 0 if there was none.
- m_valid  out  1  transaction request, high for exactly one cycle per transaction.
- m_wrbar  out  1  1 for a write, 0 for a read.
- m_addr  out  ADDR  transaction address.
- m_wdata  out  WIDTH  write data.
- m_ready  in  1  memory acknowledge, high in the cycle after m_valid.
- m_rdata  in  WIDTH  read data, valid while m_ready is high on a read.

## Operation
- Pattern: expected(a) = seed + zero-extended(a), computed modulo 2^WIDTH. The same function is used for writes and for the comparison.
- Addresses: base_addr + i for i = 0..length-1, truncated to ADDR bits, so the range wraps from 2^ADDR-1 to 0.
- States: IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, FINISH.
- IDLE:
  - start with length==0 goes to FINISH.
  - start with length>0 latches base_addr, length and seed, clears err_count, first_err_addr and timeout, then goes to WR_REQ.
- WR_REQ: drives m_valid=1, m_wrbar=1, m_addr and m_wdata for one cycle, then goes to WR_WAIT.
- WR_WAIT: m_valid=0.
  - On m_ready: the last word goes to RD_REQ with the index reset to 0; otherwise the index increments and the state returns to WR_REQ.
- RD_REQ: drives m_valid=1, m_wrbar=0 for one cycle, then goes to RD_WAIT.
- RD_WAIT: on m_ready, compares m_rdata with expected(addr).
  - A mismatch increments err_count; on the first mismatch of the run it also records first_err_addr.
  - Then either goes to the next RD_REQ or, after the last word, to FINISH.
- Timeout: a counter runs in WR_WAIT and RD_WAIT while m_ready=0. When it reaches TIMEOUT, the block sets timeout=1 and goes to FINISH; the counter clears on every REQ state.
- FINISH: done=1 for one cycle, pass = (err_count==0 && !timeout), then goes to IDLE.
- start while busy is ignored.
- m_ready outside the WAIT states is ignored.
- m_wdata holds its last value during reads; m_wrbar defaults to 0 when idle.

## Timing
- All outputs are registered.
- Reset values: every output is 0, the state is IDLE, all counters are 0.
- Reset mid-run: m_valid drops at the reset edge, no done pulse is produced, and results clear to 0.
- Each transaction takes 2 cycles (REQ, WAIT) when the memory answers with 1-cycle ready.
- done rises 4*length+1 cycles after the edge that samples start; this covers length==0, which gives 1 cycle.
- busy rises on the edge after start and falls on the edge that leaves FINISH.
- Back-to-back runs: start is accepted in the first IDLE cycle after FINISH.

## Structure
- Shared package mem_if_pkg holds:
  - WIDTH and ADDR defaults, shared with the memory.
  - the state enum type.
  - the expected-pattern function.
- No sub-module is needed. The datapath (index counter, timeout counter, comparator) is small enough to stay in this block.

## Test plan
- Basic run: base_addr=0x10, length=4, seed=0xA5A50000 against a correct memory model. Writes land at 0x10..0x13 with data 0xA5A50010..0xA5A50013; done comes at cycle 17; pass=1, err_count=0.
- Error injection: the model flips bit 0 on reads of 0x12 and 0x13. Expect err_count=2, first_err_addr=0x12, pass=0.
- Address wrap: base_addr=0xFE, length=4. Transactions go to 0xFE, 0xFF, 0x00, 0x01 and the run passes. Full-range run with length=256 finishes with done at cycle 1025.
- Zero length: length=0. Expect no m_valid, done at cycle 1, pass=1.
- Timeout: m_ready tied to 0, TIMEOUT=8. Expect a single write request, then timeout=1, pass=0 and one done pulse.
- Reset and busy start: rst asserted during the read phase clears every output and returns to IDLE. A start pulse issued while busy is ignored, so exactly one done pulse is produced.
